// File: rtl/exu_alu_dpath_arb.sv
// exu_alu_dpath_arb: arbitrated, registered ALU datapath shared by NREQ requestors
module exu_alu_dpath_arb #(
  parameter int XLEN  = 32,
  parameter int NREQ  = 2,
  parameter bit RR_EN = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid_i,
  output logic [NREQ-1:0]      req_ready_o,
  input  logic [NREQ*4-1:0]    req_op_i,
  input  logic [NREQ*XLEN-1:0] req_op1_i,
  input  logic [NREQ*XLEN-1:0] req_op2_i,
  output logic [NREQ-1:0]      rsp_valid_o,
  input  logic [NREQ-1:0]      rsp_ready_i,
  output logic [XLEN-1:0]      rsp_res_o,
  output logic                 rsp_zero_o
);
  localparam int SW = $clog2(XLEN);
  localparam int PW = NREQ > 1 ? $clog2(NREQ) : 1;
  logic [NREQ-1:0] rsp_valid_q, rsp_valid_d, grant;
  logic [XLEN-1:0] rsp_res_q, rsp_res_d, op1, op2, res;
  logic [PW-1:0]   ptr_q, ptr_d, gidx;
  logic [PW:0]     j;
  logic [3:0]      op;
  logic [XLEN:0]   ext1, ext2, sum;
  logic [SW-1:0]   amt;
  logic            slot_free, found, sub, uns;
  // only the holder's rsp_ready can free the slot
  assign slot_free = ~|rsp_valid_q | |(rsp_valid_q & rsp_ready_i);
  // first valid requestor at or after the search start wins
  always_comb begin
    gidx  = '0;
    found = 1'b0;
    j     = '0;
    for (int k = 0; k < NREQ; k++) begin
      j = (RR_EN ? {1'b0, ptr_q} : '0) + (PW+1)'(k);
      j = j >= (PW+1)'(NREQ) ? j - (PW+1)'(NREQ) : j;
      if (!found && req_valid_i[j[PW-1:0]]) begin
        found = 1'b1;
        gidx  = j[PW-1:0];
      end
    end
    grant = NREQ'(found && slot_free && !rst) << gidx;
  end
  assign req_ready_o = grant;
  assign op   = req_op_i[{gidx, 2'b00} +: 4];
  assign op1  = req_op1_i[gidx*XLEN +: XLEN];
  assign op2  = req_op2_i[gidx*XLEN +: XLEN];
  assign sub  = op == 4'd1 || op == 4'd9 || op == 4'd10;
  assign uns  = op == 4'd10;
  assign ext1 = {~uns & op1[XLEN-1], op1};
  assign ext2 = {~uns & op2[XLEN-1], op2};
  assign sum  = ext1 + (sub ? ~ext2 : ext2) + {{XLEN{1'b0}}, sub};
  assign amt  = op2[SW-1:0];
  // result select; reserved opcodes yield zero
  always_comb begin
    case (op)
      4'd0, 4'd1:  res = sum[XLEN-1:0];
      4'd2:        res = op2;
      4'd3:        res = op1 & op2;
      4'd4:        res = op1 | op2;
      4'd5:        res = op1 ^ op2;
      4'd6:        res = op1 << amt;
      4'd7:        res = op1 >> amt;
      4'd8:        res = XLEN'($signed(op1) >>> amt);
      4'd9, 4'd10: res = {{(XLEN-1){1'b0}}, sum[XLEN]};
      default:     res = '0;
    endcase
  end
  // accept overrides drain, giving back-to-back throughput
  always_comb begin
    rsp_valid_d = |grant ? grant : slot_free ? '0 : rsp_valid_q;
    rsp_res_d   = |grant ? res : rsp_res_q;
    ptr_d       = RR_EN && |grant ? (gidx == PW'(NREQ-1) ? '0 : gidx + 1'b1) : ptr_q;
  end
  // slot and pointer registers
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid_q <= '0;
      rsp_res_q   <= '0;
      ptr_q       <= '0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_res_q   <= rsp_res_d;
      ptr_q       <= ptr_d;
    end
  end
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_res_o   = rsp_res_q;
  assign rsp_zero_o  = ~|rsp_res_q;
endmodule
